degenerate_demux1to6: RTL and testbench
=======================================

Name: degenerate_demux1to6

Overview:
- Registered 1-to-6 demultiplexer. It is the distributing counterpart of the 6-to-1 selector in the ALU datapath.
- One 32-bit input word is steered by a 3-bit select to one of six output lanes. Each lane has a one-entry holding buffer and a valid/ready handshake.
- Select codes 6 and 7 are degenerate: the word is accepted and dropped, and the drop is flagged and counted.
- Sits between the ALU result bus and the per-unit consumers: write-back, flags, shifter feedback, and so on.

Parameters:
- WIDTH, 32, data width of the input word and of each output lane.
- NUM_OUT, 6, number of real lanes. Fixed at 6 in this revision; select codes NUM_OUT..7 are degenerate.
- CNT_W, 16, width of the saturating drop counter.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  reset, synchronous and active-high.
- in_data  in  WIDTH  word to distribute.
- in_sel  in  3  destination lane. 0..5 are valid; 6 and 7 are degenerate.
- in_valid  in  1  in_data/in_sel are valid.
- in_ready  out  1  block can accept this cycle.
- out_data  out  NUM_OUT*WIDTH  lane k occupies bits [k*WIDTH +: WIDTH].
- out_valid  out  NUM_OUT  lane k buffer is full.
- out_ready  in  NUM_OUT  lane k consumer accepts.
- drop_pulse  out  1  one-cycle pulse: a degenerate-select word was dropped.
- drop_count  out  CNT_W  saturating count of dropped words.

Behaviour:
- Reset, sampled on a clk edge with rst=1:
  - out_valid=0, out_data=0, drop_pulse=0, drop_count=0.
  - in_ready=0 while rst=1.
- Input transfer occurs on a cycle with in_valid=1 and in_ready=1.
- in_ready is combinational:
  - For in_sel<6: in_ready = !out_valid[in_sel] || out_ready[in_sel].
  - For in_sel>=6: in_ready = 1.
  - It depends only on in_sel, out_valid and out_ready, never on in_valid.
- Lane transfer occurs on a cycle with out_valid[k]=1 and out_ready[k]=1.
- Latency: a word accepted at edge N with in_sel=k appears on lane k with out_valid[k]=1 after edge N. It is visible in cycle N+1.
- Lane buffer rules:
  - Data and valid are held stable while out_valid[k]=1 and out_ready[k]=0. The lane does not overwrite or drop data.
  - Simultaneous drain and fill on the same lane: out_valid[k] stays 1 and out_data lane k takes the new word. The result is full throughput, one word per cycle per lane.
  - Drain without fill: out_valid[k] goes to 0. out_data lane k keeps its last value; consumers must ignore it.
  - Lanes are independent. A stalled lane never blocks traffic to another lane, only inputs whose in_sel addresses the stalled lane.
- Degenerate select (6 or 7), on transfer:
  - No lane changes.
  - drop_pulse=1 for exactly the following cycle.
  - drop_count increments by 1 and saturates at all-ones; it never wraps.
  - Back-to-back drops keep drop_pulse high for each cycle and the count advances by one per drop.
- in_valid=1 with in_ready=0: the input must hold in_data/in_sel until accepted. The block does not check this.
- Reset mid-operation: buffered words are discarded with no handshake completion. drop_count clears.
- X on in_sel while in_valid=0 must not disturb state.

Decomposition:
- Package demux_pkg:
  - DATA_W=32, NUM_OUT=6, SEL_W=3, CNT_W=16.
  - Localparam SEL_DEGEN_MIN=3'd6.
  - Function is_degenerate(sel).
- One sub-module, demux_lane_buffer: a single-entry valid/ready register.
  - Ports: clk, rst, fill, fill_data, ready, valid, data, can_fill.
  - Instantiated NUM_OUT times via generate.
- The top handles select decode, the in_ready mux, and the drop logic.

Test Plan:
- Reset: hold rst=1 for 2 cycles with in_valid=1 -> in_ready=0, out_valid=6'b0, out_data all 0, drop_count=0.
- Single route: in_data=32'hDEADBEEF, in_sel=3, out_ready=6'h3F, 1 cycle -> next cycle out_valid=6'b001000 and lane3=DEADBEEF; the cycle after, out_valid=0.
- Backpressure: out_ready[2]=0, send A to lane 2 -> lane 2 holds A.
  - A second word to lane 2 sees in_ready=0.
  - A word to lane 4 is still accepted.
  - Raise out_ready[2] -> A drains, and the second word is accepted in the same cycle.
- Degenerate: in_sel=6 then 7 back-to-back -> no out_valid change, drop_pulse high for 2 cycles, drop_count=2.
- Saturation: force 65537 drops with in_sel=7 -> drop_count=16'hFFFF, no wrap.
- Random: port of the mux bench, 20 iterations of $random data with $urandom_range(0,7) sel and random out_ready -> the scoreboard matches per-lane FIFO order and drop count.

Source files
------------

// File: rtl/degenerate_demux1to6_pkg.sv
// Shared widths, the degenerate-select boundary and its decode helper.
package demux_pkg;

  localparam int DATA_W  = 32;
  localparam int NUM_OUT = 6;
  localparam int SEL_W   = 3;
  localparam int CNT_W   = 16;

  localparam logic [SEL_W-1:0] SEL_DEGEN_MIN = 3'd6;

  typedef logic [DATA_W-1:0] word_t;
  typedef logic [SEL_W-1:0]  sel_t;

  function automatic logic is_degenerate(input sel_t sel);
    return (sel >= SEL_DEGEN_MIN);
  endfunction

endpackage

// File: rtl/degenerate_demux1to6_if.sv
// Input word/select handshake, per-lane output handshakes and drop status.
interface degenerate_demux1to6_if #(
  parameter int WIDTH   = demux_pkg::DATA_W,
  parameter int NUM_OUT = demux_pkg::NUM_OUT,
  parameter int SEL_W   = demux_pkg::SEL_W,
  parameter int CNT_W   = demux_pkg::CNT_W
);

  logic [WIDTH-1:0]         in_data;
  logic [SEL_W-1:0]         in_sel;
  logic                     in_valid;
  logic                     in_ready;
  logic [NUM_OUT*WIDTH-1:0] out_data;
  logic [NUM_OUT-1:0]       out_valid;
  logic [NUM_OUT-1:0]       out_ready;
  logic                     drop_pulse;
  logic [CNT_W-1:0]         drop_count;

  // Producer of words and consumer of all lanes.
  modport master (
    output in_data, in_sel, in_valid, out_ready,
    input  in_ready, out_data, out_valid, drop_pulse, drop_count
  );

  // The demux itself.
  modport slave (
    input  in_data, in_sel, in_valid, out_ready,
    output in_ready, out_data, out_valid, drop_pulse, drop_count
  );

endinterface

// File: rtl/degenerate_demux1to6_lane_buffer.sv
// Purpose: single-entry valid/ready holding register for one output lane.
// Latency: one cycle from fill to valid.
// Backpressure: can_fill drops while full and not draining; data holds until accepted.
module demux_lane_buffer #(
  parameter int WIDTH = demux_pkg::DATA_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             fill,
  input  logic [WIDTH-1:0] fill_data,
  input  logic             ready,
  output logic             valid,
  output logic [WIDTH-1:0] data,
  output logic             can_fill
);

  assign can_fill = !valid || ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      data  <= '0;
    end else if (fill) begin
      valid <= 1'b1;
      data  <= fill_data;
    end else if (ready) begin
      // Drained without refill: data keeps its last value, valid marks it stale.
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/degenerate_demux1to6.sv
// Purpose: registered 1-to-6 demux; selects 6/7 drop the word and bump a saturating counter.
// Latency: one cycle from input transfer to lane valid or drop_pulse.
// Backpressure: in_ready follows only the addressed lane; degenerate selects are always ready.
module degenerate_demux1to6 #(
  parameter int WIDTH   = demux_pkg::DATA_W,
  parameter int NUM_OUT = demux_pkg::NUM_OUT,
  parameter int CNT_W   = demux_pkg::CNT_W
) (
  input logic                   clk,
  input logic                   rst,
  degenerate_demux1to6_if.slave bus
);

  import demux_pkg::*;

  localparam int NUM_SEL = 1 << SEL_W;

  logic [NUM_OUT-1:0] can_fill;
  logic [NUM_OUT-1:0] fill;
  logic [NUM_SEL-1:0] can_fill_ext;
  logic               accept;
  logic               drop;
  logic               drop_pulse_q;
  logic [CNT_W-1:0]   drop_count_q;

  // Degenerate codes read as permanently ready so one index covers every select.
  assign can_fill_ext = {{(NUM_SEL - NUM_OUT){1'b1}}, can_fill};
  assign bus.in_ready = !rst && can_fill_ext[bus.in_sel];
  assign accept       = bus.in_valid && bus.in_ready;
  assign drop         = accept && is_degenerate(bus.in_sel);

  for (genvar g = 0; g < NUM_OUT; g++) begin : g_lane
    assign fill[g] = accept && (bus.in_sel == SEL_W'(g));

    demux_lane_buffer #(
      .WIDTH (WIDTH)
    ) u_lane (
      .clk       (clk),
      .rst       (rst),
      .fill      (fill[g]),
      .fill_data (bus.in_data),
      .ready     (bus.out_ready[g]),
      .valid     (bus.out_valid[g]),
      .data      (bus.out_data[g*WIDTH +: WIDTH]),
      .can_fill  (can_fill[g])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      drop_pulse_q <= 1'b0;
      drop_count_q <= '0;
    end else begin
      drop_pulse_q <= drop;
      if (drop && (drop_count_q != '1)) begin
        drop_count_q <= drop_count_q + 1'b1;
      end
    end
  end

  assign bus.drop_pulse = drop_pulse_q;
  assign bus.drop_count = drop_count_q;

endmodule

// File: tb/tb_degenerate_demux1to6.sv
// Directed and small randomized checks of the 1-to-6 demux against hand-computed values.
module tb_degenerate_demux1to6;

  import demux_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  logic [31:0] q [NUM_OUT][$];
  int          model_cnt;
  logic        prev_drop;
  int          n1;

  degenerate_demux1to6_if bus ();

  degenerate_demux1to6 dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] lane(input int k);
    return bus.out_data[k*DATA_W +: DATA_W];
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One randomized cycle: compare against the lane queues, then advance the model.
  task automatic evaluate();
    logic [2:0] sel;
    logic       exp_rdy;
    logic       acc;
    sel     = bus.in_sel;
    exp_rdy = (sel >= 3'd6) || (q[sel].size() == 0) || bus.out_ready[sel];
    chk("rnd_pulse", bus.drop_pulse, prev_drop);
    chk("rnd_count", bus.drop_count, model_cnt);
    chk("rnd_in_ready", bus.in_ready, exp_rdy);
    for (int k = 0; k < NUM_OUT; k++) begin
      chk($sformatf("rnd_valid%0d", k), bus.out_valid[k], q[k].size() != 0);
      if (q[k].size() != 0 && bus.out_ready[k]) begin
        chk($sformatf("rnd_lane%0d", k), lane(k), q[k].pop_front());
      end
    end
    acc       = bus.in_valid && exp_rdy;
    prev_drop = acc && (sel >= 3'd6);
    if (prev_drop) begin
      if (model_cnt != 65535) model_cnt++;
    end else if (acc) begin
      q[sel].push_back(bus.in_data);
    end
  endtask

  initial begin
    // Reset held two cycles with a valid input present.
    rst           = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_sel    = 3'd0;
    bus.in_data   = 32'h1234_5678;
    bus.out_ready = '0;
    step();
    step();
    chk("rst_in_ready", bus.in_ready, 1'b0);
    chk("rst_out_valid", bus.out_valid, 6'b0);
    for (int k = 0; k < NUM_OUT; k++) chk($sformatf("rst_lane%0d", k), lane(k), 32'h0);
    chk("rst_drop_count", bus.drop_count, 16'h0);
    chk("rst_drop_pulse", bus.drop_pulse, 1'b0);
    rst          = 1'b0;
    bus.in_valid = 1'b0;
    step();

    // Single route to lane 3.
    bus.in_data   = 32'hDEAD_BEEF;
    bus.in_sel    = 3'd3;
    bus.in_valid  = 1'b1;
    bus.out_ready = 6'h3F;
    #1;
    chk("single_in_ready", bus.in_ready, 1'b1);
    step();
    bus.in_valid = 1'b0;
    #1;
    chk("single_valid", bus.out_valid, 6'b001000);
    chk("single_lane3", lane(3), 32'hDEAD_BEEF);
    step();
    chk("single_drained", bus.out_valid, 6'b0);
    chk("single_lane3_hold", lane(3), 32'hDEAD_BEEF);

    // Backpressure on lane 2 while lane 4 keeps flowing.
    bus.out_ready = 6'b111011;
    bus.in_data   = 32'hA0A0_A0A0;
    bus.in_sel    = 3'd2;
    bus.in_valid  = 1'b1;
    step();
    bus.in_data = 32'hB0B0_B0B0;
    #1;
    chk("bp_blocked", bus.in_ready, 1'b0);
    chk("bp_valid_a", bus.out_valid, 6'b000100);
    chk("bp_lane2_a", lane(2), 32'hA0A0_A0A0);
    step();
    bus.in_sel  = 3'd4;
    bus.in_data = 32'hC0C0_C0C0;
    #1;
    chk("bp_other_ready", bus.in_ready, 1'b1);
    chk("bp_lane2_held", lane(2), 32'hA0A0_A0A0);
    step();
    bus.in_sel    = 3'd2;
    bus.in_data   = 32'hB0B0_B0B0;
    bus.out_ready = 6'h3F;
    #1;
    chk("bp_valid_ac", bus.out_valid, 6'b010100);
    chk("bp_lane4_c", lane(4), 32'hC0C0_C0C0);
    chk("bp_refill_ready", bus.in_ready, 1'b1);
    step();
    bus.in_valid = 1'b0;
    #1;
    chk("bp_valid_b", bus.out_valid, 6'b000100);
    chk("bp_lane2_b", lane(2), 32'hB0B0_B0B0);
    step();
    chk("bp_empty", bus.out_valid, 6'b0);

    // Degenerate selects back-to-back.
    bus.in_data  = 32'h1111_1111;
    bus.in_sel   = 3'd6;
    bus.in_valid = 1'b1;
    #1;
    chk("degen_ready", bus.in_ready, 1'b1);
    step();
    bus.in_sel = 3'd7;
    #1;
    chk("degen_pulse1", bus.drop_pulse, 1'b1);
    chk("degen_count1", bus.drop_count, 16'd1);
    chk("degen_valid1", bus.out_valid, 6'b0);
    step();
    bus.in_valid = 1'b0;
    #1;
    chk("degen_pulse2", bus.drop_pulse, 1'b1);
    chk("degen_count2", bus.drop_count, 16'd2);
    chk("degen_valid2", bus.out_valid, 6'b0);
    step();
    chk("degen_pulse_end", bus.drop_pulse, 1'b0);
    chk("degen_count_end", bus.drop_count, 16'd2);

    // Reset mid-operation discards a held word and clears the counter.
    bus.out_ready = 6'b0;
    bus.in_sel    = 3'd1;
    bus.in_data   = 32'h5555_5555;
    bus.in_valid  = 1'b1;
    step();
    bus.in_valid = 1'b0;
    #1;
    chk("mid_held", bus.out_valid, 6'b000010);
    rst = 1'b1;
    step();
    chk("mid_rst_valid", bus.out_valid, 6'b0);
    chk("mid_rst_lane1", lane(1), 32'h0);
    chk("mid_rst_count", bus.drop_count, 16'h0);
    rst           = 1'b0;
    bus.out_ready = 6'h3F;
    step();

    // Randomized traffic, then a drain phase.
    model_cnt = 0;
    prev_drop = 1'b0;
    for (int it = 0; it < 20; it++) begin
      bus.in_data   = $random;
      bus.in_sel    = 3'($urandom_range(0, 7));
      bus.out_ready = 6'($urandom_range(0, 63));
      bus.in_valid  = 1'b1;
      #1;
      evaluate();
      step();
    end
    for (int it = 0; it < 3; it++) begin
      bus.in_valid  = 1'b0;
      bus.out_ready = 6'h3F;
      #1;
      evaluate();
      step();
    end
    for (int k = 0; k < NUM_OUT; k++) chk($sformatf("rnd_left%0d", k), q[k].size(), 0);

    // Saturation of the drop counter.
    bus.in_sel   = 3'd7;
    bus.in_valid = 1'b1;
    n1           = 65534 - model_cnt;
    repeat (n1) step();
    chk("sat_fffe", bus.drop_count, 16'hFFFE);
    repeat (65537 - n1) step();
    bus.in_valid = 1'b0;
    #1;
    chk("sat_ffff", bus.drop_count, 16'hFFFF);
    chk("sat_pulse", bus.drop_pulse, 1'b1);
    step();
    chk("sat_nowrap", bus.drop_count, 16'hFFFF);
    chk("sat_pulse_end", bus.drop_pulse, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
